// File: rtl/dff_pkg.sv
// Shared helpers for the dff_pipe delay line. Optional synchronous clear is
// enabled by defining DFF_PIPE_CLR_EN.
package dff_pkg;

    // Counter width able to hold 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 3;

endpackage

// File: rtl/dff_stage.sv
// One pipeline slot: WIDTH-bit data register plus its valid flag.
// The clr input exists only when DFF_PIPE_CLR_EN is defined.
module dff_stage
    import dff_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef DFF_PIPE_CLR_EN
    input  logic             clr,
`endif
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_d;
    logic             valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (en) begin
            data_d  = d;
            valid_d = d_valid;
        end
`ifdef DFF_PIPE_CLR_EN
        // Clear wins over advance so the incoming word is dropped.
        if (clr) begin
            data_d  = RST_VAL;
            valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= RST_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q       = data_q;
    assign q_valid = valid_q;

endmodule

// File: rtl/dff_pipe.sv
// Stallable fixed-latency delay line of DEPTH dff_stage slots with an
// occupancy counter. Define DFF_PIPE_CLR_EN to add the synchronous clr port.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter int               DEPTH   = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
`ifdef DFF_PIPE_CLR_EN
    input  logic                         clr,
`endif
    input  logic [WIDTH-1:0]             d,
    input  logic                         d_valid,
    output logic [WIDTH-1:0]             q,
    output logic                         q_valid,
    output logic [occ_width(DEPTH)-1:0]  occ
);

    localparam int OCC_W = occ_width(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             valid;
    } stage_t;

    stage_t           stage_in;
    stage_t           stage_last;
    logic [WIDTH-1:0] data_chain  [DEPTH+1];
    logic             valid_chain [DEPTH+1];
    logic [OCC_W-1:0] occ_d;
    logic [OCC_W-1:0] occ_q;

    assign stage_in       = '{data: d, valid: d_valid};
    assign data_chain[0]  = stage_in.data;
    assign valid_chain[0] = stage_in.valid;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        dff_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
`ifdef DFF_PIPE_CLR_EN
            .clr     (clr),
`endif
            .d       (data_chain[g]),
            .d_valid (valid_chain[g]),
            .q       (data_chain[g+1]),
            .q_valid (valid_chain[g+1])
        );
    end

    assign stage_last = '{data: data_chain[DEPTH], valid: valid_chain[DEPTH]};

    // Entry and exit on the same edge cancel; the counter tracks the chain
    // exactly because it advances on the same enable.
    always_comb begin
        occ_d = occ_q;
        if (en) begin
            occ_d = occ_q + OCC_W'(stage_in.valid) - OCC_W'(stage_last.valid);
        end
`ifdef DFF_PIPE_CLR_EN
        if (clr) begin
            occ_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign q       = stage_last.data;
    assign q_valid = stage_last.valid;
    assign occ     = occ_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed scoreboard bench for dff_pipe (WIDTH=8, DEPTH=3).
module tb_dff_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int OCC_W = 2;

    logic             clk;
    logic             rst;
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [OCC_W-1:0] occ;

    logic [WIDTH-1:0] exp_q[$];
    int               n_vec;
    int               n_err;
    logic             en_s;
    logic             rst_s;

    dff_pipe #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (8'h00)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
`ifdef DFF_PIPE_CLR_EN
        .clr     (clr),
`endif
        .d       (d),
        .d_valid (d_valid),
        .q       (q),
        .q_valid (q_valid),
        .occ     (occ)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: a new word reaches the output only on an enabled edge
    always @(posedge clk) begin
        en_s  <= en;
        rst_s <= rst;
    end

    always @(negedge clk) begin
        if (rst && rst_s && en_s && q_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: q=%h q_valid=1, expected no valid output", q);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (q !== e) begin
                    n_err++;
                    $display("FAIL sb_data: q=%h expected %h", q, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            assert (occ <= DEPTH)
            else $error("occupancy out of range: occ=%0d", occ);
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // driver: apply one edge of stimulus, then check hand-computed occ/q_valid
    task automatic step(input logic e, input logic [WIDTH-1:0] dd, input logic dv,
                        input logic c, input int eocc, input logic eqv,
                        input logic chq, input logic [WIDTH-1:0] eq, input string name);
        en      = e;
        d       = dd;
        d_valid = dv;
        clr     = c;
        if (c) exp_q.delete();
        else if (e && dv) exp_q.push_back(dd);
        @(posedge clk);
        @(negedge clk);
        check({name, "_occ"}, int'(occ), eocc);
        check({name, "_qv"}, int'(q_valid), int'(eqv));
        if (chq) check({name, "_q"}, int'(q), int'(eq));
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b0;
        en      = 1'b1;
        clr     = 1'b0;
        d       = 8'hAA;
        d_valid = 1'b1;

        // reset holds everything at zero despite active inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_q", int'(q), 0);
            check("rst_qv", int'(q_valid), 0);
            check("rst_occ", int'(occ), 0);
        end
        rst = 1'b1;

        // fill / drain
        step(1, 8'h11, 1, 0, 1, 0, 1, 8'h00, "fill1");
        step(1, 8'h22, 1, 0, 2, 0, 1, 8'h00, "fill2");
        step(1, 8'h33, 1, 0, 3, 1, 0, 8'h00, "fill3");
        step(1, 8'h44, 1, 0, 3, 1, 0, 8'h00, "fill4");
        step(1, 8'h00, 0, 0, 2, 1, 0, 8'h00, "drain1");
        step(1, 8'h00, 0, 0, 1, 1, 0, 8'h00, "drain2");
        step(1, 8'h00, 0, 0, 0, 0, 1, 8'h00, "drain3");

        // stall mid-stream: inputs ignored, outputs frozen
        step(1, 8'h55, 1, 0, 1, 0, 1, 8'h00, "st_in1");
        step(1, 8'h66, 1, 0, 2, 0, 1, 8'h00, "st_in2");
        for (int i = 0; i < 4; i++)
            step(0, 8'(($urandom_range(0, 255))), 1, 0, 2, 0, 1, 8'h00, "stall");
        step(1, 8'h77, 1, 0, 3, 1, 0, 8'h00, "st_res1");
        step(1, 8'h00, 0, 0, 2, 1, 0, 8'h00, "st_res2");
        step(1, 8'h00, 0, 0, 1, 1, 0, 8'h00, "st_res3");
        step(1, 8'h00, 0, 0, 0, 0, 1, 8'h00, "st_res4");

        // bubbles: invalid slots still carry their data
        step(1, 8'hA1, 1, 0, 1, 0, 0, 8'h00, "bub1");
        step(1, 8'hB2, 0, 0, 1, 0, 0, 8'h00, "bub2");
        step(1, 8'hA3, 1, 0, 2, 1, 0, 8'h00, "bub3");
        step(1, 8'hB4, 0, 0, 1, 0, 1, 8'hB2, "bub4");
        step(1, 8'hA5, 1, 0, 2, 1, 0, 8'h00, "bub5");
        step(1, 8'hB6, 0, 0, 1, 0, 1, 8'hB4, "bub6");
        step(1, 8'h00, 0, 0, 1, 1, 0, 8'h00, "bub7");
        step(1, 8'h00, 0, 0, 0, 0, 1, 8'hB6, "bub8");

        // async reset between edges on a full pipe
        step(1, 8'hC1, 1, 0, 1, 0, 0, 8'h00, "ar1");
        step(1, 8'hC2, 1, 0, 2, 0, 0, 8'h00, "ar2");
        step(1, 8'hC3, 1, 0, 3, 1, 0, 8'h00, "ar3");
        #2 rst = 1'b0;
        exp_q.delete();
        #1;
        check("arst_q", int'(q), 0);
        check("arst_qv", int'(q_valid), 0);
        check("arst_occ", int'(occ), 0);
        @(negedge clk);
        check("arst_hold_occ", int'(occ), 0);
        rst = 1'b1;
        step(1, 8'hD1, 1, 0, 1, 0, 0, 8'h00, "post_rst1");
        step(1, 8'h00, 0, 0, 1, 0, 0, 8'h00, "post_rst2");
        step(1, 8'h00, 0, 0, 1, 1, 0, 8'h00, "post_rst3");
        step(1, 8'h00, 0, 0, 0, 0, 0, 8'h00, "post_rst4");

`ifdef DFF_PIPE_CLR_EN
        // synchronous clear beats enable; 0x55 is never captured
        step(1, 8'hE1, 1, 0, 1, 0, 0, 8'h00, "cl1");
        step(1, 8'hE2, 1, 0, 2, 0, 0, 8'h00, "cl2");
        step(1, 8'hE3, 1, 0, 3, 1, 0, 8'h00, "cl3");
        step(1, 8'h55, 1, 1, 0, 0, 1, 8'h00, "clr");
        for (int i = 0; i < 3; i++)
            step(1, 8'h00, 0, 0, 0, 0, 1, 8'h00, "clr_after");
`endif

        en = 1'b0;
        d_valid = 1'b0;
        @(negedge clk);
        check("sb_leftover", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
